// File: rtl/mem_bus_arbiter.sv
// Two-master (m0 = data, m1 = fetch) to one-slave arbiter for an Avalon-style memory bus.
// Optional macro ROUND_ROBIN_EN: alternate tie priority after each completed transfer (default: m0 wins ties).
module mem_bus_arbiter #(
   parameter int READ_LATENCY = 1,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [31:0]       m0_writedata,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [3:0]        m0_byteenable,
   output logic              m0_waitrequest,
   output logic [31:0]       m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [31:0]       m1_writedata,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [3:0]        m1_byteenable,
   output logic              m1_waitrequest,
   output logic [31:0]       m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] s_address,
   output logic [31:0]       s_writedata,
   output logic              s_read,
   output logic              s_write,
   output logic [3:0]        s_byteenable,
   input  logic              s_waitrequest,
   input  logic [31:0]       s_readdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [2:0] LAT = 3'(READ_LATENCY);

   state_t      r_state, w_state_nxt;
   logic        r_gnt, w_gnt_nxt;
   logic        r_prio, w_prio_nxt;
   logic [2:0]  r_cnt, w_cnt_nxt;
   logic [31:0] r_rdata0, r_rdata1;
   logic        w_req0, w_req1, w_pick;
   logic        w_sel_write, w_sel_read;
   logic        w_valid0, w_valid1;

   assign w_req0      = m0_read | m0_write;
   assign w_req1      = m1_read | m1_write;
   // A simultaneous read and write from one master is treated as a write.
   assign w_sel_write = r_gnt ? m1_write : m0_write;
   assign w_sel_read  = r_gnt ? (m1_read & ~m1_write) : (m0_read & ~m0_write);

`ifdef ROUND_ROBIN_EN
   localparam logic RR_EN = 1'b1;
   assign w_pick = (w_req0 & w_req1) ? r_prio : w_req1;
`else
   localparam logic RR_EN = 1'b0;
   assign w_pick = ~w_req0;
`endif

   // State, grant, priority pointer, latency counter and held read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_gnt    <= 1'b0;
         r_prio   <= 1'b0;
         r_cnt    <= 3'd0;
         r_rdata0 <= 32'd0;
         r_rdata1 <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_prio  <= w_prio_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_valid0) r_rdata0 <= s_readdata;
         else          r_rdata0 <= r_rdata0;
         if (w_valid1) r_rdata1 <= s_readdata;
         else          r_rdata1 <= r_rdata1;
      end
   end

   // Next-state logic and bus/handshake outputs.
   always_comb begin
      w_state_nxt    = r_state;
      w_gnt_nxt      = r_gnt;
      w_prio_nxt     = r_prio;
      w_cnt_nxt      = r_cnt;
      s_address      = '0;
      s_writedata    = 32'd0;
      s_byteenable   = 4'd0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      w_valid0       = 1'b0;
      w_valid1       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req0 | w_req1) begin
               w_state_nxt = ISSUE;
               w_gnt_nxt   = w_pick;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         ISSUE: begin
            s_address    = r_gnt ? m1_address    : m0_address;
            s_writedata  = r_gnt ? m1_writedata  : m0_writedata;
            s_byteenable = r_gnt ? m1_byteenable : m0_byteenable;
            s_write      = w_sel_write;
            s_read       = w_sel_read;
            if (!s_waitrequest) begin
               if (r_gnt) m1_waitrequest = 1'b0;
               else       m0_waitrequest = 1'b0;
               if (w_sel_write) begin
                  w_state_nxt = IDLE;
                  w_prio_nxt  = RR_EN ? ~r_prio : r_prio;
               end else begin
                  w_state_nxt = RESP;
                  w_cnt_nxt   = LAT;
               end
            end else begin
               w_state_nxt = ISSUE;
            end
         end
         RESP: begin
            // Counter value 1 marks the cycle the slave's read data is valid.
            if (r_cnt == 3'd1) begin
               if (r_gnt) w_valid1 = 1'b1;
               else       w_valid0 = 1'b1;
               w_state_nxt = IDLE;
               w_prio_nxt  = RR_EN ? ~r_prio : r_prio;
            end else begin
               w_cnt_nxt = r_cnt - 3'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign m0_readdatavalid = w_valid0;
   assign m1_readdatavalid = w_valid1;
   assign m0_readdata      = w_valid0 ? s_readdata : r_rdata0;
   assign m1_readdata      = w_valid1 ? s_readdata : r_rdata1;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: read data scoreboarded through per-master queues,
// plus a READ_LATENCY=3 instance for latency and reset-in-RESP behaviour.
module tb_mem_bus_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset;
   logic [1:0][31:0] m_address, m_writedata;
   logic [1:0]       m_read, m_write;
   logic [1:0][3:0]  m_be;
   logic             m0_wait, m1_wait, m0_valid, m1_valid;
   logic [31:0]      m0_rdata, m1_rdata;
   logic [31:0]      s_address, s_wdata, s_rdata;
   logic             s_read, s_write, s_wait;
   logic [3:0]       s_be;
   wire  [1:0]       m_wait = {m1_wait, m0_wait};

   logic [31:0] mem [64];
   logic [31:0] q0[$], q1[$];
   int          g_m[$], g_c[$];
   int          cyc = 0;
   int          errors = 0, checks = 0;

   // Second instance (READ_LATENCY=3)
   logic        b_reset, b_m0_read;
   logic        b_m0_wait, b_m0_valid, b_m1_wait, b_m1_valid;
   logic [31:0] b_m0_rdata, b_m1_rdata, b_s_address, b_s_wdata;
   logic        b_s_read, b_s_write;
   logic [3:0]  b_s_be;

   mem_bus_arbiter #(.READ_LATENCY(1), .ADDR_W(32)) u_dut (
      .clk(clk), .reset(reset),
      .m0_address(m_address[0]), .m0_writedata(m_writedata[0]), .m0_read(m_read[0]),
      .m0_write(m_write[0]), .m0_byteenable(m_be[0]), .m0_waitrequest(m0_wait),
      .m0_readdata(m0_rdata), .m0_readdatavalid(m0_valid),
      .m1_address(m_address[1]), .m1_writedata(m_writedata[1]), .m1_read(m_read[1]),
      .m1_write(m_write[1]), .m1_byteenable(m_be[1]), .m1_waitrequest(m1_wait),
      .m1_readdata(m1_rdata), .m1_readdatavalid(m1_valid),
      .s_address(s_address), .s_writedata(s_wdata), .s_read(s_read), .s_write(s_write),
      .s_byteenable(s_be), .s_waitrequest(s_wait), .s_readdata(s_rdata)
   );

   mem_bus_arbiter #(.READ_LATENCY(3), .ADDR_W(32)) u_dut3 (
      .clk(clk), .reset(b_reset),
      .m0_address(32'hBFC00040), .m0_writedata(32'd0), .m0_read(b_m0_read),
      .m0_write(1'b0), .m0_byteenable(4'hF), .m0_waitrequest(b_m0_wait),
      .m0_readdata(b_m0_rdata), .m0_readdatavalid(b_m0_valid),
      .m1_address(32'd0), .m1_writedata(32'd0), .m1_read(1'b0),
      .m1_write(1'b0), .m1_byteenable(4'h0), .m1_waitrequest(b_m1_wait),
      .m1_readdata(b_m1_rdata), .m1_readdatavalid(b_m1_valid),
      .s_address(b_s_address), .s_writedata(b_s_wdata), .s_read(b_s_read), .s_write(b_s_write),
      .s_byteenable(b_s_be), .s_waitrequest(1'b0), .s_readdata(32'hA5A50003)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory model with one-cycle read latency.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (s_write && !s_wait)
         for (int b = 0; b < 4; b++)
            if (s_be[b]) mem[s_address[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
      if (s_read && !s_wait) s_rdata <= mem[s_address[7:2]];
   end

   // Read-data scoreboard and grant log.
   always @(negedge clk) begin
      if (m0_valid === 1'b1) begin
         if (q0.size() == 0) chk("m0_rvalid_unexpected", 32'(m0_valid), 32'd0);
         else                chk("m0_rdata", m0_rdata, q0.pop_front());
      end
      if (m1_valid === 1'b1) begin
         if (q1.size() == 0) chk("m1_rvalid_unexpected", 32'(m1_valid), 32'd0);
         else                chk("m1_rdata", m1_rdata, q1.pop_front());
      end
      if (m0_wait === 1'b0) begin g_m.push_back(0); g_c.push_back(cyc); end
      if (m1_wait === 1'b0) begin g_m.push_back(1); g_c.push_back(cyc); end
   end

   task automatic do_reset();
      reset = 1'b1;
      m_read = 2'b00; m_write = 2'b00;
      s_wait = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      g_m.delete(); g_c.delete();
   endtask

   task automatic xfer(input int idx, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] exp);
      int n;
      m_address[idx] = addr; m_writedata[idx] = data; m_be[idx] = 4'hF;
      m_write[idx] = wr; m_read[idx] = ~wr;
      if (!wr) begin
         if (idx == 0) q0.push_back(exp);
         else          q1.push_back(exp);
      end
      n = 0;
      do begin @(negedge clk); n++; end while (m_wait[idx] && n < 60);
      chk($sformatf("m%0d_accept", idx), 32'(m_wait[idx]), 32'd0);
      @(posedge clk); #1;
      m_read[idx] = 1'b0; m_write[idx] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      mem[0] = 32'h3C02BFC0;
      mem[2] = 32'h12345678;
      m_address = '0; m_writedata = '0; m_be = '0;
      b_reset = 1'b1; b_m0_read = 1'b0;

      // Reset, then idle bus for 5 cycles
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_flags", 32'({s_read, s_write, m0_wait, m1_wait, m0_valid, m1_valid}), 32'b001100);
         chk("idle_addr", s_address, 32'd0);
         chk("idle_rdata", m0_rdata | m1_rdata, 32'd0);
      end

      // Single m1 read, zero stall
      @(posedge clk); #1;
      m_address[1] = 32'hBFC00000; m_read[1] = 1'b1; q1.push_back(32'h3C02BFC0);
      @(negedge clk);
      chk("rd_c0_sread", 32'(s_read), 32'd0);
      @(negedge clk);
      chk("rd_c1_sread", 32'(s_read), 32'd1);
      chk("rd_c1_saddr", s_address, 32'hBFC00000);
      chk("rd_c1_m1wait", 32'(m1_wait), 32'd0);
      chk("rd_c1_m0wait", 32'(m0_wait), 32'd1);
      @(posedge clk); #1 m_read[1] = 1'b0;
      @(negedge clk);
      chk("rd_c2_valid", 32'(m1_valid), 32'd1);
      chk("rd_c2_m0valid", 32'(m0_valid), 32'd0);
      @(negedge clk);
      chk("rd_c3_valid", 32'(m1_valid), 32'd0);
      chk("rd_c3_hold", m1_rdata, 32'h3C02BFC0);

      // Simultaneous m0 write and m1 read
      do_reset();
      fork
         xfer(0, 1'b1, 32'hBFC00010, 32'hDEADBEEF, 32'd0);
         xfer(1, 1'b0, 32'hBFC00000, 32'd0, 32'h3C02BFC0);
      join
      repeat (3) @(negedge clk);
      chk("tie_ngrants", 32'(g_m.size()), 32'd2);
      if (g_m.size() == 2) begin
         chk("tie_first", 32'(g_m[0]), 32'd0);
         chk("tie_second", 32'(g_m[1]), 32'd1);
         chk("tie_gap", 32'(g_c[1] - g_c[0]), 32'd2);
      end
      chk("mem4", mem[4], 32'hDEADBEEF);

      // m0 read with 3 stall cycles
      do_reset();
      s_wait = 1'b1;
      m_address[0] = 32'hBFC00008; m_be[0] = 4'hF; m_read[0] = 1'b1; q0.push_back(32'h12345678);
      @(negedge clk);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk($sformatf("stall_c%0d_sread", i), 32'(s_read), 32'd1);
         chk($sformatf("stall_c%0d_saddr", i), s_address, 32'hBFC00008);
         chk($sformatf("stall_c%0d_m0wait", i), 32'(m0_wait), (i < 4) ? 32'd1 : 32'd0);
         if (i == 3) begin @(posedge clk); #1 s_wait = 1'b0; end
      end
      @(posedge clk); #1 m_read[0] = 1'b0;
      @(negedge clk);
      chk("stall_valid", 32'(m0_valid), 32'd1);

      // Continuous contention
      do_reset();
`ifdef ROUND_ROBIN_EN
      fork
         for (int k = 0; k < 4; k++) xfer(0, 1'b1, 32'hBFC00020 + 32'(4*k), 32'h100 + 32'(k), 32'd0);
         for (int k = 0; k < 4; k++) xfer(1, 1'b1, 32'hBFC00060 + 32'(4*k), 32'h200 + 32'(k), 32'd0);
      join
      chk("rr_ngrants", 32'(g_m.size()), 32'd8);
      for (int k = 0; k < 8 && k < g_m.size(); k++)
         chk($sformatf("rr_grant%0d", k), 32'(g_m[k]), 32'(k % 2));
`else
      fork
         for (int k = 0; k < 8; k++) xfer(0, 1'b1, 32'hBFC00020 + 32'(4*k), 32'h100 + 32'(k), 32'd0);
         xfer(1, 1'b1, 32'hBFC00080, 32'h200, 32'd0);
      join
      chk("fp_ngrants", 32'(g_m.size()), 32'd9);
      for (int k = 0; k < 9 && k < g_m.size(); k++)
         chk($sformatf("fp_grant%0d", k), 32'(g_m[k]), (k < 8) ? 32'd0 : 32'd1);
`endif

      // READ_LATENCY=3: normal read, then reset during RESP
      b_reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 b_reset = 1'b0; b_m0_read = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("l3_c1_wait", 32'(b_m0_wait), 32'd0);
      @(posedge clk); #1 b_m0_read = 1'b0;
      for (int i = 2; i <= 4; i++) begin
         @(negedge clk);
         chk($sformatf("l3_c%0d_valid", i), 32'(b_m0_valid), (i == 4) ? 32'd1 : 32'd0);
      end
      chk("l3_rdata", b_m0_rdata, 32'hA5A50003);
      @(posedge clk); #1 b_m0_read = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("l3r_c1_wait", 32'(b_m0_wait), 32'd0);
      @(posedge clk); #1 b_m0_read = 1'b0; b_reset = 1'b1;
      @(negedge clk);
      @(posedge clk); #1 b_reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("l3r_flags", 32'({b_m0_valid, b_m1_valid, b_m0_wait, b_m1_wait, b_s_read}), 32'b00110);
      end
      chk("l3r_rdata", b_m0_rdata, 32'd0);

      chk("q0_empty", 32'(q0.size()), 32'd0);
      chk("q1_empty", 32'(q1.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
